// File: rtl/rlbp_pkg.sv
// rlbp_pkg: shared types and helpers for the RLBP scan sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the FSM state enum, default phase lengths and a one-hot decoder.
package rlbp_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_INT  = 3'd2,
        S_SH   = 3'd3,
        S_CMP  = 3'd4,
        S_NEXT = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    // Default phase lengths in clock cycles.
    localparam int T_RST_DEF = 4;
    localparam int T_SH_DEF  = 2;
    // Must be >= 3 so the synchronized comparator value belongs to the
    // current pixel when it is captured.
    localparam int T_CMP_DEF = 3;

    // Widest pixel count supported; onehot() returns this many bits.
    localparam int MAX_PIX = 16;

    // One-hot decode of idx within an n-bit field; zero when idx is out of range.
    function automatic logic [MAX_PIX-1:0] onehot(input int idx, input int n);
        logic [MAX_PIX-1:0] r;
        r = '0;
        if (idx >= 0 && idx < n && idx < MAX_PIX) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rlbp_scan_seq_if.sv
// rlbp_scan_seq_if: LBP code hand-off from the scan sequencer to the register logic.
// Latency: n/a (wires only). Backpressure: code held while code_ready_i is low.
// Ports: code_o/code_valid_o/done_o driven by master, code_ready_i driven by slave.
interface rlbp_scan_seq_if #(
    parameter int N_PIX = 12
);
    logic [N_PIX-1:0] code_o;
    logic             code_valid_o;
    logic             code_ready_i;
    logic             done_o;

    modport master (
        output code_o,
        output code_valid_o,
        output done_o,
        input  code_ready_i
    );

    modport slave (
        input  code_o,
        input  code_valid_o,
        input  done_o,
        output code_ready_i
    );
endinterface

// File: rtl/rlbp_sync2.sv
// rlbp_sync2: two-flop synchronizer for a single asynchronous bit.
// Latency: 2 cycles. Backpressure: none.
// Ports: clk, rst (sync active-high, clears both flops to 0), d async in, q synced out.
module rlbp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/rlbp_scan_seq.sv
// rlbp_scan_seq: sequences the photodiode LBP front end, one neighbour comparison per pixel.
// Latency: N_PIX*(T_RST+int+T_SH+T_CMP+1) cycles from start to code_valid_o.
// Backpressure: stalls in OUT holding code_o until code_ready_i; abort_i drops the scan.
// Ports: wb_clk_i/wb_rst_i; start_i, abort_i, int_cycles_i, cmp_i (async) inputs;
//        pd_a_o/pd_b_o pixel selects, analog switch controls, counter_rst_o, busy_o;
//        code hand-off through rlbp_scan_seq_if.master.
module rlbp_scan_seq
    import rlbp_pkg::*;
#(
    parameter int N_PIX = 12,
    parameter int T_RST = T_RST_DEF,
    parameter int T_SH  = T_SH_DEF,
    parameter int T_CMP = T_CMP_DEF,
    parameter int INT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [INT_W-1:0] int_cycles_i,
    input  logic             cmp_i,
    output logic [N_PIX-1:0] pd_a_o,
    output logic [N_PIX-1:0] pd_b_o,
    output logic             sh_rst_o,
    output logic             sw1_o,
    output logic             sh_o,
    output logic             sw2_o,
    output logic             sh_cmp_o,
    output logic             counter_rst_o,
    output logic             busy_o,
    rlbp_scan_seq_if.master  code_if
);

    localparam int T_MAX = max_int(T_RST, max_int(T_SH, T_CMP));
    localparam int CNT_W = max_int(INT_W, $clog2(T_MAX + 1));
    localparam int K_W   = $clog2(N_PIX);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [K_W-1:0]     k;
    logic [N_PIX-1:0]   code;
    logic [INT_W-1:0]   int_len;
    logic               phase_last;
    logic               last_pix;
    logic               cmp_sync;
    logic [K_W-1:0]     k_b;
    logic [MAX_PIX-1:0] sel_a, sel_b;

    rlbp_sync2 u_cmp_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (cmp_i),
        .q   (cmp_sync)
    );

    assign last_pix = (k == K_W'(N_PIX - 1));
    // Neighbour of the last pixel wraps back to pixel 0.
    assign k_b      = last_pix ? '0 : k + K_W'(1);
    assign sel_a    = onehot(int'(k), N_PIX);
    assign sel_b    = onehot(int'(k_b), N_PIX);

    // Next-state logic. Each timed phase ends when cnt reaches its terminal value.
    always_comb begin
        state_nxt  = state;
        phase_last = 1'b0;
        case (state)
            S_RST: phase_last = (cnt == CNT_W'(T_RST - 1));
            // int_len is never 0, so the subtraction cannot underflow.
            S_INT: phase_last = (cnt == (CNT_W'(int_len) - CNT_W'(1)));
            S_SH:  phase_last = (cnt == CNT_W'(T_SH - 1));
            S_CMP: phase_last = (cnt == CNT_W'(T_CMP - 1));
            default: phase_last = 1'b0;
        endcase

        case (state)
            S_IDLE: if (start_i && !abort_i) state_nxt = S_RST;
            S_RST:  if (phase_last) state_nxt = S_INT;
            S_INT:  if (phase_last) state_nxt = S_SH;
            S_SH:   if (phase_last) state_nxt = S_CMP;
            S_CMP:  if (phase_last) state_nxt = S_NEXT;
            S_NEXT: state_nxt = last_pix ? S_OUT : S_RST;
            S_OUT:  if (code_if.code_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides every transition, including the OUT handshake.
        if (abort_i && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            k       <= '0;
            code    <= '0;
            int_len <= '0;
        end else begin
            state <= state_nxt;

            // Phase counter restarts on every state change and idles at 0.
            if (state_nxt != state || state == S_IDLE || state == S_OUT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == S_IDLE && start_i && !abort_i) begin
                int_len <= (int_cycles_i == '0) ? INT_W'(1) : int_cycles_i;
                k       <= '0;
                code    <= '0;
            end

            if (abort_i && state != S_IDLE) begin
                code <= '0;
            end else begin
                if (state == S_CMP && phase_last) begin
                    code[k] <= cmp_sync;
                end
                if (state == S_NEXT && !last_pix) begin
                    k <= k + K_W'(1);
                end
            end
        end
    end

    // Outputs are a pure decode of state, so reset and abort clear them immediately.
    always_comb begin
        pd_a_o               = '0;
        pd_b_o               = '0;
        sh_rst_o             = 1'b0;
        sw1_o                = 1'b0;
        sh_o                 = 1'b0;
        sw2_o                = 1'b0;
        sh_cmp_o             = 1'b0;
        counter_rst_o        = 1'b0;
        busy_o               = (state != S_IDLE);
        code_if.code_o       = '0;
        code_if.code_valid_o = 1'b0;
        code_if.done_o       = 1'b0;

        if (state == S_RST || state == S_INT || state == S_SH || state == S_CMP) begin
            pd_a_o = sel_a[N_PIX-1:0];
            pd_b_o = sel_b[N_PIX-1:0];
        end

        case (state)
            S_RST: begin
                sh_rst_o      = 1'b1;
                sw1_o         = 1'b1;
                counter_rst_o = (k == '0) && (cnt == '0);
            end
            S_SH: begin
                sh_o  = 1'b1;
                sw2_o = 1'b1;
            end
            S_CMP: begin
                sh_cmp_o = 1'b1;
                sw2_o    = 1'b1;
            end
            S_OUT: begin
                code_if.code_o       = code;
                code_if.code_valid_o = 1'b1;
                code_if.done_o       = code_if.code_ready_i && !abort_i;
            end
            default: ;
        endcase
    end

endmodule
